// File: rtl/ibex_wb_stage.sv
// Writeback buffer: 2-entry FIFO between EX and the register-file write port,
// with a combinational forwarding lookup over buffered entries and a retire counter.
module ibex_wb_stage #(
  parameter bit FWD_EN = 1'b1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_we_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              flush_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic              rf_ready_i,
  input  logic [4:0]        fwd_raddr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [31:0]       retire_cnt_o
);

  logic              we_q    [2];
  logic [4:0]        waddr_q [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [1:0]        count_q;
  logic              rptr_q;
  logic              wptr_q;
  logic [31:0]       retire_cnt_q;

  logic push;
  logic pop;
  logic head_we;
  logic not_empty;

  assign not_empty  = (count_q != 2'd0);
  assign ex_ready_o = (count_q != 2'd2);
  assign head_we    = we_q[rptr_q];
  assign push       = ex_valid_i && ex_ready_o && !flush_i;
  // A head without a write drains immediately; a writing head waits for the port.
  assign pop        = not_empty && (!head_we || rf_ready_i);

  assign rf_we_o      = not_empty && head_we;
  assign rf_waddr_o   = not_empty ? waddr_q[rptr_q] : 5'd0;
  assign rf_wdata_o   = not_empty ? wdata_q[rptr_q] : '0;
  assign retire_cnt_o = retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      rptr_q       <= 1'b0;
      wptr_q       <= 1'b0;
      retire_cnt_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        we_q[i]    <= 1'b0;
        waddr_q[i] <= 5'd0;
        wdata_q[i] <= '0;
      end
    end else begin
      if (push) begin
        // x0 writes are demoted so they can never reach the register file.
        we_q[wptr_q]    <= ex_we_i && (ex_waddr_i != 5'd0);
        waddr_q[wptr_q] <= ex_waddr_i;
        wdata_q[wptr_q] <= ex_wdata_i;
      end
      if (pop) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
      if (flush_i) begin
        count_q <= 2'd0;
        rptr_q  <= 1'b0;
        wptr_q  <= 1'b0;
      end else begin
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
        if (push) wptr_q <= ~wptr_q;
        if (pop)  rptr_q <= ~rptr_q;
      end
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      logic old_hit;
      logic young_hit;
      logic young_idx;

      // With two entries the younger one sits just past the read pointer.
      assign young_idx = ~rptr_q;
      assign old_hit   = not_empty && we_q[rptr_q] && (waddr_q[rptr_q] == fwd_raddr_i)
                         && (fwd_raddr_i != 5'd0);
      assign young_hit = (count_q == 2'd2) && we_q[young_idx]
                         && (waddr_q[young_idx] == fwd_raddr_i) && (fwd_raddr_i != 5'd0);

      always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (young_hit) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = wdata_q[young_idx];
        end else if (old_hit) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = wdata_q[rptr_q];
        end
      end
    end else begin : g_no_fwd
      assign fwd_hit_o  = 1'b0;
      assign fwd_data_o = '0;
    end
  endgenerate

endmodule

// File: tb/tb_ibex_wb_stage.sv
// Bench for ibex_wb_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ibex_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        flush_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_ready_i;
  logic [4:0]  fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic [31:0] retire_cnt_o;

  ibex_wb_stage #(.FWD_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_we_i      (ex_we_i),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .flush_i      (flush_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_ready_i   (rf_ready_i),
    .fwd_raddr_i  (fwd_raddr_i),
    .fwd_hit_o    (fwd_hit_o),
    .fwd_data_o   (fwd_data_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_retire;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare every output against the model, then advance the model past the coming edge.
  task automatic model_check_and_step();
    logic        e_hit;
    logic [31:0] e_fd;
    logic        do_pop;
    logic        do_push;
    entry_t      e;
    e_hit = 1'b0;
    e_fd  = 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_hit && mq[i].we && mq[i].waddr == fwd_raddr_i && fwd_raddr_i != 5'd0) begin
        e_hit = 1'b1;
        e_fd  = mq[i].wdata;
      end
    end
    chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, mq.size() < 2});
    chk("rf_we", {31'd0, rf_we_o}, {31'd0, mq.size() > 0 && mq[0].we});
    chk("rf_waddr", {27'd0, rf_waddr_o}, mq.size() > 0 ? {27'd0, mq[0].waddr} : 32'd0);
    chk("rf_wdata", rf_wdata_o, mq.size() > 0 ? mq[0].wdata : 32'd0);
    chk("fwd_hit", {31'd0, fwd_hit_o}, {31'd0, e_hit});
    chk("fwd_data", fwd_data_o, e_fd);
    chk("retire_cnt", retire_cnt_o, m_retire);

    if (rst) begin
      mq.delete();
      m_retire = 32'd0;
    end else begin
      do_pop  = mq.size() > 0 && (!mq[0].we || rf_ready_i);
      do_push = ex_valid_i && mq.size() < 2 && !flush_i;
      if (do_pop) begin
        m_retire = m_retire + 32'd1;
        void'(mq.pop_front());
      end
      if (flush_i) mq.delete();
      else if (do_push) begin
        e.we    = ex_we_i && ex_waddr_i != 5'd0;
        e.waddr = ex_waddr_i;
        e.wdata = ex_wdata_i;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic fl, input logic rdy, input logic [4:0] ra);
    @(negedge clk);
    rst = r; ex_valid_i = v; ex_we_i = we; ex_waddr_i = a; ex_wdata_i = d;
    flush_i = fl; rf_ready_i = rdy; fwd_raddr_i = ra;
    #1;
    model_check_and_step();
  endtask

  initial begin
    m_retire = 32'd0;
    rst = 1'b1; ex_valid_i = 1'b0; ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    flush_i = 1'b0; rf_ready_i = 1'b0; fwd_raddr_i = 5'd0;
    @(negedge clk);
    @(negedge clk);
    mq.delete();

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit_o}, 32'd0);
    chk("rst_retire", retire_cnt_o, 32'd0);

    // Single write with one-cycle latency
    cycle(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lat_we", {31'd0, rf_we_o}, 32'd1);
    chk("lat_waddr", {27'd0, rf_waddr_o}, 32'd5);
    chk("lat_wdata", rf_wdata_o, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lat_empty", {31'd0, rf_we_o}, 32'd0);
    chk("lat_retire", retire_cnt_o, 32'd1);

    // Backpressure: full buffer refuses a third result, drains in order
    cycle(0, 1, 1, 5'd1, 32'h11, 0, 0, 0);
    cycle(0, 1, 1, 5'd2, 32'h22, 0, 0, 0);
    cycle(0, 1, 1, 5'd3, 32'h33, 0, 0, 0);
    chk("full_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("full_hold_addr", {27'd0, rf_waddr_o}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("drain1_addr", {27'd0, rf_waddr_o}, 32'd1);
    chk("drain1_data", rf_wdata_o, 32'h11);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("drain2_addr", {27'd0, rf_waddr_o}, 32'd2);
    chk("drain2_data", rf_wdata_o, 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("drain_empty", {31'd0, rf_we_o}, 32'd0);
    chk("drain_retire", retire_cnt_o, 32'd3);

    // Forwarding: younger of two matching entries wins; x0 never hits
    cycle(0, 1, 1, 5'd7, 32'hA, 0, 0, 0);
    cycle(0, 1, 1, 5'd7, 32'hB, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 5'd7);
    chk("fwd_young_hit", {31'd0, fwd_hit_o}, 32'd1);
    chk("fwd_young_data", fwd_data_o, 32'hB);
    cycle(0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("fwd_x0_hit", {31'd0, fwd_hit_o}, 32'd0);
    chk("fwd_x0_data", fwd_data_o, 32'd0);

    // Flush with two entries and a concurrent push
    cycle(0, 1, 1, 5'd9, 32'h99, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("flush_rf_we", {31'd0, rf_we_o}, 32'd0);
    chk("flush_retire", retire_cnt_o, 32'd3);

    // x0 write drains without a register-file write
    cycle(0, 1, 1, 5'd0, 32'h55, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_no_we", {31'd0, rf_we_o}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_retire", retire_cnt_o, 32'd4);

    // Retire counter wrap
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    m_retire = 32'hFFFFFFFF;
    cycle(0, 1, 1, 5'd4, 32'h44, 0, 1, 0);
    chk("wrap_pre", retire_cnt_o, 32'hFFFFFFFF);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("wrap_zero", retire_cnt_o, 32'd0);

    // Reset during a stalled write
    cycle(0, 1, 1, 5'd3, 32'h33, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_we", {31'd0, rf_we_o}, 32'd1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_mid_we", {31'd0, rf_we_o}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
